// File: rtl/br_flow_deserializer.sv
// Rebuilds wide pop flits from narrow push flits, recovering packet boundaries
// and the number of unfilled tail slices of a short final flit.
module br_flow_deserializer #(
  parameter int PushWidth = 1,
  parameter int PopWidth = 2,
  parameter int MetadataWidth = 1,
  parameter bit DeserializeMostSignificantFirst = 1,
  parameter bit EnableAssertFinalNotValid = 1,
  localparam int DeserializationRatio = PopWidth / PushWidth,
  localparam int SerFlitIdWidth = DeserializationRatio > 1 ? $clog2(DeserializationRatio) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      push_ready,
  input  logic                      push_valid,
  input  logic [PushWidth-1:0]      push_data,
  input  logic                      push_last,
  input  logic [MetadataWidth-1:0]  push_metadata,
  input  logic                      pop_ready,
  output logic                      pop_valid,
  output logic [PopWidth-1:0]       pop_data,
  output logic                      pop_last,
  output logic [SerFlitIdWidth-1:0] pop_last_dont_care_count,
  output logic [MetadataWidth-1:0]  pop_metadata
);

  localparam int R = DeserializationRatio;

  assign pop_last     = push_last;
  assign pop_metadata = push_metadata;

  if (R == 1) begin : g_passthru
    assign push_ready               = pop_ready;
    assign pop_valid                = push_valid;
    assign pop_data                 = push_data;
    assign pop_last_dont_care_count = '0;
  end else begin : g_deser
    localparam logic [SerFlitIdWidth-1:0] LastCnt = SerFlitIdWidth'(R - 1);

    logic [SerFlitIdWidth-1:0] cnt;
    logic                      done;
    logic                      push_hs;
    logic                      pop_hs;

    assign done       = push_last || (cnt == LastCnt);
    assign push_ready = done ? pop_ready : 1'b1;
    assign pop_valid  = push_valid && done;
    assign push_hs    = push_valid && push_ready;
    assign pop_hs     = pop_valid && pop_ready;

    // pop handshake restarts assembly whether the flit filled or ended early
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (pop_hs) begin
        cnt <= '0;
      end else if (push_hs) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign pop_last_dont_care_count = push_last ? (LastCnt - cnt) : '0;

    for (genvar i = 0; i < R; i++) begin : g_slice
      localparam logic [SerFlitIdWidth-1:0] Idx = SerFlitIdWidth'(i);
      localparam int Pos = DeserializeMostSignificantFirst ? (R - 1 - i) : i;

      logic [PushWidth-1:0] slice;

      if (i < R - 1) begin : g_stored
        logic [PushWidth-1:0] slot;

        always_ff @(posedge clk) begin
          if (push_hs && !done && (cnt == Idx)) begin
            slot <= push_data;
          end
        end

        // tail slices past the current count are zeroed so stale data never leaks
        assign slice = (cnt > Idx) ? slot : ((cnt == Idx) ? push_data : '0);
      end else begin : g_cut
        assign slice = (cnt == Idx) ? push_data : '0;
      end

      assign pop_data[Pos*PushWidth +: PushWidth] = slice;
    end

    logic [MetadataWidth-1:0] meta_q;

    always_ff @(posedge clk) begin
      if (push_hs) begin
        meta_q <= push_metadata;
      end
    end

    metadata_constant_a : assert property (@(posedge clk) disable iff (rst)
      (push_valid && cnt != '0) |-> (push_metadata == meta_q));

    last_implies_push_last_a : assert property (@(posedge clk) disable iff (rst)
      (pop_valid && pop_last) |-> push_last);

    dont_care_nonzero_c : cover property (@(posedge clk) disable iff (rst)
      pop_valid && pop_last && (pop_last_dont_care_count != '0));
  end

  push_stable_a : assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));

  push_backpressure_c : cover property (@(posedge clk) disable iff (rst)
    push_valid && !push_ready);

  pop_valid_a : assert property (@(posedge clk) disable iff (rst)
    pop_valid |-> push_valid);

  final begin
    if (EnableAssertFinalNotValid) begin
      final_not_valid_a : assert (!push_valid);
    end
  end

endmodule

// File: tb/tb_br_flow_deserializer.sv
// Drives MS-first and LS-first 8->32 instances plus an 8->8 pass-through from
// shared push stimulus and compares them against a packet-list reference model.
module tb_br_flow_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_last;
  logic [2:0] push_metadata;
  logic       pop_ready;

  logic        ms_push_ready, ms_pop_valid, ms_pop_last;
  logic [31:0] ms_pop_data;
  logic [1:0]  ms_dc;
  logic [2:0]  ms_meta;
  logic        ls_push_ready, ls_pop_valid, ls_pop_last;
  logic [31:0] ls_pop_data;
  logic [1:0]  ls_dc;
  logic [2:0]  ls_meta;
  logic        pt_push_ready, pt_pop_valid, pt_pop_last;
  logic [7:0]  pt_pop_data;
  logic [0:0]  pt_dc;
  logic [2:0]  pt_meta;

  br_flow_deserializer #(.PushWidth(8), .PopWidth(32), .MetadataWidth(3),
    .DeserializeMostSignificantFirst(1)) dut_ms (
    .clk(clk), .rst(rst), .push_ready(ms_push_ready), .push_valid(push_valid),
    .push_data(push_data), .push_last(push_last), .push_metadata(push_metadata),
    .pop_ready(pop_ready), .pop_valid(ms_pop_valid), .pop_data(ms_pop_data),
    .pop_last(ms_pop_last), .pop_last_dont_care_count(ms_dc), .pop_metadata(ms_meta));

  br_flow_deserializer #(.PushWidth(8), .PopWidth(32), .MetadataWidth(3),
    .DeserializeMostSignificantFirst(0)) dut_ls (
    .clk(clk), .rst(rst), .push_ready(ls_push_ready), .push_valid(push_valid),
    .push_data(push_data), .push_last(push_last), .push_metadata(push_metadata),
    .pop_ready(pop_ready), .pop_valid(ls_pop_valid), .pop_data(ls_pop_data),
    .pop_last(ls_pop_last), .pop_last_dont_care_count(ls_dc), .pop_metadata(ls_meta));

  br_flow_deserializer #(.PushWidth(8), .PopWidth(8), .MetadataWidth(3)) dut_pt (
    .clk(clk), .rst(rst), .push_ready(pt_push_ready), .push_valid(push_valid),
    .push_data(push_data), .push_last(push_last), .push_metadata(push_metadata),
    .pop_ready(pop_ready), .pop_valid(pt_pop_valid), .pop_data(pt_pop_data),
    .pop_last(pt_pop_last), .pop_last_dont_care_count(pt_dc), .pop_metadata(pt_meta));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [7:0] pkt[$];

  logic        s_ms_ready, s_ms_valid, s_ls_ready, s_ls_valid;
  logic [31:0] s_ms_data, s_ls_data;
  logic [1:0]  s_ms_dc, s_ls_dc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flit k of the packet lands in slice R-1-k (MS-first) or slice k (LS-first).
  function automatic logic [31:0] model_data(input bit msf);
    logic [31:0] d;
    int n;
    d = '0;
    n = pkt.size();
    for (int k = 0; k < n; k++)
      d |= 32'(pkt[k]) << (8 * (msf ? 3 - k : k));
    d |= 32'(push_data) << (8 * (msf ? 3 - n : n));
    return d;
  endfunction

  task automatic check_all();
    int n;
    logic done, exp_ready, exp_valid;
    logic [1:0] exp_dc;
    n = pkt.size();
    done = push_last || (n == 3);
    exp_ready = done ? pop_ready : 1'b1;
    exp_valid = push_valid && done;
    exp_dc = push_last ? 2'(3 - n) : 2'd0;
    chk("ms_push_ready", ms_push_ready, exp_ready);
    chk("ms_pop_valid", ms_pop_valid, exp_valid);
    chk("ls_push_ready", ls_push_ready, exp_ready);
    chk("ls_pop_valid", ls_pop_valid, exp_valid);
    if (exp_valid) begin
      chk("ms_pop_data", ms_pop_data, model_data(1'b1));
      chk("ms_pop_last", ms_pop_last, push_last);
      chk("ms_dc", ms_dc, exp_dc);
      chk("ms_meta", ms_meta, push_metadata);
      chk("ls_pop_data", ls_pop_data, model_data(1'b0));
      chk("ls_pop_last", ls_pop_last, push_last);
      chk("ls_dc", ls_dc, exp_dc);
      chk("ls_meta", ls_meta, push_metadata);
    end
    chk("pt_push_ready", pt_push_ready, pop_ready);
    chk("pt_pop_valid", pt_pop_valid, push_valid);
    chk("pt_pop_data", pt_pop_data, push_data);
    chk("pt_pop_last", pt_pop_last, push_last);
    chk("pt_dc", pt_dc, 1'b0);
    chk("pt_meta", pt_meta, push_metadata);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic [2:0] m, input logic pr, input logic r);
    logic done;
    push_valid = v;
    push_data = d;
    push_last = l;
    push_metadata = m;
    pop_ready = pr;
    rst = r;
    @(negedge clk);
    s_ms_ready = ms_push_ready;
    s_ms_valid = ms_pop_valid;
    s_ms_data = ms_pop_data;
    s_ms_dc = ms_dc;
    s_ls_ready = ls_push_ready;
    s_ls_valid = ls_pop_valid;
    s_ls_data = ls_pop_data;
    s_ls_dc = ls_dc;
    if (chk_en) check_all();
    @(posedge clk);
    done = l || (pkt.size() == 3);
    if (r) pkt.delete();
    else if (v && (done ? pr : 1'b1)) begin
      if (done) pkt.delete();
      else pkt.push_back(d);
    end
    #1;
  endtask

  initial begin
    logic v, l, pr, stall;
    logic [7:0] d;
    logic [2:0] m;
    logic [7:0] flits [4];

    @(posedge clk);
    #1;
    cycle(0, 8'h00, 0, 3'd0, 1, 1);
    cycle(0, 8'h00, 0, 3'd0, 1, 1);
    chk_en = 1'b1;

    // reset state
    cycle(0, 8'h00, 0, 3'd0, 1, 0);
    chk("reset_pop_valid", s_ms_valid, 1'b0);
    chk("reset_push_ready", s_ms_ready, 1'b1);

    // full flit, MS-first
    flits = '{8'hBA, 8'hAD, 8'hF0, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      cycle(1, flits[i], 0, 3'd6, 1, 0);
      chk("full_push_ready", s_ms_ready, 1'b1);
    end
    chk("full_pop_valid", s_ms_valid, 1'b1);
    chk("full_pop_data", s_ms_data, 32'hBAADF00D);
    chk("full_dc", s_ms_dc, 2'd0);

    // short last packet, LS-first
    cycle(1, 8'h0D, 0, 3'd5, 1, 0);
    cycle(1, 8'hF0, 0, 3'd5, 1, 0);
    cycle(1, 8'hAD, 1, 3'd5, 1, 0);
    chk("short_pop_valid", s_ls_valid, 1'b1);
    chk("short_pop_data", s_ls_data, 32'h00ADF00D);
    chk("short_dc", s_ls_dc, 2'd1);
    cycle(1, 8'h77, 1, 3'd2, 1, 0);
    chk("short_restart_data", s_ls_data, 32'h00000077);
    chk("short_restart_dc", s_ls_dc, 2'd3);

    // backpressure on the completing flit
    for (int i = 0; i < 3; i++) cycle(1, flits[i], 0, 3'd6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'h0D, 0, 3'd6, 0, 0);
      chk("bp_push_ready", s_ms_ready, 1'b0);
      chk("bp_pop_data", s_ms_data, 32'hBAADF00D);
    end
    cycle(1, 8'h0D, 0, 3'd6, 1, 0);
    chk("bp_release_valid", s_ms_valid, 1'b1);
    cycle(0, 8'h00, 0, 3'd6, 1, 0);

    // reset mid-flit discards the partial flit
    cycle(1, 8'hEE, 0, 3'd1, 1, 0);
    cycle(1, 8'hEF, 0, 3'd1, 1, 0);
    cycle(0, 8'h00, 0, 3'd1, 1, 1);
    flits = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1, flits[i], 0, 3'd3, 1, 0);
      if (i < 3) chk("rst_no_pop", s_ms_valid, 1'b0);
    end
    chk("rst_pop_data", s_ms_data, 32'h11223344);

    // throughput: two back-to-back full flits then a single-flit packet
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 3'd4, 1, 0);
      chk("tput_push_ready", s_ms_ready, 1'b1);
      chk("tput_pop_valid", s_ms_valid, (i % 4) == 3);
    end
    cycle(1, 8'h5A, 1, 3'd7, 1, 0);
    chk("single_pop_data", s_ms_data, 32'h5A000000);
    chk("single_dc", s_ms_dc, 2'd3);

    // randomized traffic; inputs are held whenever any instance may stall
    stall = 1'b0;
    v = 0; d = 0; l = 0; m = 0;
    for (int i = 0; i < 400; i++) begin
      if (!stall) begin
        v = $urandom_range(0, 3) != 0;
        d = 8'($urandom);
        l = $urandom_range(0, 3) == 0;
        if (pkt.size() == 0) m = 3'($urandom);
      end
      pr = $urandom_range(0, 2) != 0;
      stall = v && !pr;
      cycle(v, d, l, m, pr, 0);
    end

    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, m, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_flow_deserializer.md
# br_flow_deserializer

Reassembles narrow push flits into wide pop flits using ready-valid handshakes on both sides. It is the receive-side counterpart of the flow serializer. It sits downstream of a narrow link and rebuilds the original wide bus. It also recovers packet boundaries and tail "don't care" slice counts.

## Interface
- PushWidth, default 1: narrow flit width; ≥1.
- PopWidth, default 2: wide flit width; must be a multiple of PushWidth.
- MetadataWidth, default 1: sideband width; ≥1.
- DeserializeMostSignificantFirst, default 1: if 1, the first push flit lands in the most-significant slice; if 0, in the least-significant slice.
- EnableAssertFinalNotValid, default 1: assert no valid is pending at end of test.
- DeserializationRatio (localparam) = PopWidth/PushWidth, written R below.
- SerFlitIdWidth (localparam) = R>1 ? $clog2(R) : 1.

Ports:
- clk, input, 1: posedge clock.
- rst, input, 1: reset; synchronous, active-high.
- push_ready, output, 1: push-side ready.
- push_valid, input, 1: push-side valid.
- push_data, input, PushWidth: narrow flit.
- push_last, input, 1: last narrow flit of the packet.
- push_metadata, input, MetadataWidth: sideband; must be identical for all push flits of one pop flit.
- pop_ready, input, 1: pop-side ready.
- pop_valid, output, 1: pop-side valid.
- pop_data, output, PopWidth: reassembled wide flit.
- pop_last, output, 1: equals push_last of the completing push flit.
- pop_last_dont_care_count, output, SerFlitIdWidth: number of unfilled tail slices; 0 unless pop_last.
- pop_metadata, output, MetadataWidth: push_metadata of the completing push flit.

## Operation
- R==1: pure pass-through.
  - pop_* = push_*; push_ready = pop_ready; pop_last_dont_care_count = 0.
- R>1: slice counter `cnt` (SerFlitIdWidth bits), reset to 0. Slice storage is R-1 registers of PushWidth bits each, with no reset.
- Slice position: a push flit at count c goes to slice index R-1-c when DeserializeMostSignificantFirst=1, and to index c otherwise.
- Completing flit: `done = push_last || cnt == R-1`.
- Non-completing flit (!done):
  - push_ready = 1; pop_valid = 0.
  - On handshake, store push_data in slot c and increment cnt.
- Completing flit (done):
  - push_ready = pop_ready; pop_valid = push_valid.
  - The final slice is cut through combinationally from push_data.
  - Slices 0..cnt-1 in arrival order come from storage.
  - Tail slices beyond cnt are driven to 0.
- On pop handshake, cnt reinitialises to 0. This covers both the natural wrap at R-1 and early termination by last.
- pop_last_dont_care_count = push_last ? R-1-cnt : 0, computed mod 2^SerFlitIdWidth. The value is always <R.
- Integration assertions:
  - push valid/data stability, using the standard integration checker with backpressure cover.
  - push_metadata is constant within one pop flit. Violation is a failure, not handled.
- Implementation assertions:
  - pop_valid |-> push_valid.
  - pop_valid && pop_last |-> push_last.
  - Cover: pop_last with nonzero dont-care count.

## Timing
- Latency: 0 cycles from the completing push flit to pop_valid. Stored slices are registered one cycle after their handshake.
- Throughput: 1 push flit per cycle. Back-to-back pop flits are allowed, one every R cycles for full flits and fewer for short packets.
- Pop stability: pop outputs stay stable under pop backpressure because the push side holds the completing flit stable. While stalled, cnt and storage hold.
- Idle state: with push_valid=0, pop_valid=0 and storage holds. push_ready may be 1 during idle.
- Reset: cnt=0, pop_valid=0 (given push_valid=0). A partially assembled flit is discarded and never popped.
- Boundary: push_last at cnt==0 produces a pop flit with a single valid slice and dont-care count R-1.
- Stale data: stale storage from earlier packets never appears, because it is masked to 0 in the tail.

## Test plan
- **Full flit, MS-first.** R=4, 8→32, pop_ready=1; push BA, AD, F0, 0D with last=0 and metadata=6.
  - push_ready=1 in every cycle.
  - pop_valid only in cycle 3, with pop_data=32'hBAADF00D, pop_last=0, count=0, metadata=6.
- **Short last packet, LS-first.** Push 0D, F0, AD with last=1 on AD and metadata=5.
  - Cycle 2: pop_data=32'h00ADF00D, pop_last=1, pop_last_dont_care_count=1, metadata=5.
  - Next packet starts at cnt=0.
- **Backpressure.** As the full-flit case but pop_ready=0 for cycles 3–5.
  - push_ready=0 and pop_valid=1 with 32'hBAADF00D stable for cycles 3–5.
  - Pop and push handshake in cycle 6; cnt returns to 0.
- **Reset mid-flit.** Push 2 flits, assert rst for 1 cycle, then push 11, 22, 33, 44.
  - Exactly one pop: 32'h11223344; no pop from the partial flit.
- **Throughput.** 8 consecutive flits with pop_ready=1.
  - Pops in cycles 3 and 7 only; push_ready never drops.
  - A single-flit last packet (dont-care count 3) pops on its own cycle with data 32'hXX000000, where XX is the flit.
- **R=1 pass-through.** 8→8.
  - All outputs mirror their inputs combinationally in the same cycle; pop_last_dont_care_count=0.
